ask_uart_tx_multi: RTL and testbench
====================================

Name: ask_uart_tx_multi

Overview:
Parametrised, synthesisable successor to the ASK UART transmitter. It buffers characters in an internal axi_fifo and frames each one as start / data / optional parity / 1 or 2 stop bits. Each line bit is keyed onto a carrier taken from a sine LUT through a phase accumulator, so the output is a synthesisable ASK sample stream. It sits between a CPU register interface and a DAC sample path; no real-valued system functions are used.

Parameters:
DATA_BITS, 8, character width, 5..9
SAMPLE_WIDTH, 8, signed output sample width
SIZE, 4, log2 FIFO depth, passed to axi_fifo
LUT_ADDR_W, 6, log2 entries of the quarter-sine-free full-cycle LUT
PHASE_W, 16, phase accumulator width
CARRIER_ON_SPACE, 1, 1: carrier while line=0 and silence while line=1; 0: inverted

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fifo_in  in  DATA_BITS  character to queue
fifo_write  in  1  push strobe; ignored when fifo_full
fifo_full  out  1  FIFO cannot accept
fifo_level  out  16  FIFO free space, entries
clkdiv  in  16  clocks per bit; 0 treated as 1
phase_inc  in  PHASE_W  carrier phase step per clock
parity_mode  in  2  0 none, 1 even, 2 odd, 3 none
two_stop  in  1  1: two stop bits
tx_line  out  1  raw UART line, idle 1
ask_tx  out  SAMPLE_WIDTH  signed keyed carrier sample
baudclk  out  1  one-cycle pulse at each bit boundary
busy  out  1  frame in progress

Behaviour:
- Reset values: tx_line=1, ask_tx=0, baudclk=0, busy=0. FSM goes to IDLE, baud counter to 0, phase to 0. FIFO is cleared through its reset.
- Baud counter: runs 1..max(clkdiv,1) and wraps to 1. bit_tick = (counter==max(clkdiv,1)). baudclk is bit_tick registered one cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions happen on bit_tick only.
- IDLE→START: on bit_tick with FIFO non-empty. The head is latched into the shift register and popped the same cycle, so the pop is a one-cycle o_tready pulse.
- START→DATA. DATA shifts LSB first for DATA_BITS ticks.
- DATA→PARITY if parity_mode is 1 or 2, else DATA→STOP.
- Parity bit: XOR of data bits for even; inverted XOR for odd.
- STOP lasts 1 tick, or 2 ticks if two_stop=1.
- STOP→START directly (back-to-back frames, no idle bit) if FIFO is non-empty at the final STOP tick; else STOP→IDLE.
- Frame config: parity_mode and two_stop are sampled at IDLE/STOP→START and held for the whole frame.
- tx_line: registered. Equals the current state's bit value, with 1 in IDLE and STOP.
- busy: 1 in every state except IDLE.
- Phase accumulator: cleared to 0 on entry to START. Otherwise it adds phase_inc every clock modulo 2^PHASE_W.
- LUT: addressed by the top LUT_ADDR_W phase bits. Entry k = floor((2^(SAMPLE_WIDTH-1)-1)*sin(2πk/2^LUT_ADDR_W)), precomputed at elaboration with an integer generate or init.
- ask_tx: registered, one-cycle latency after tx_line. It is the LUT sample when keyed on (tx_line==0 with CARRIER_ON_SPACE=1), else 0.
- FIFO write while full: data dropped, no state change. Write and pop in the same cycle are both honoured.
- clkdiv changes mid-frame: take effect at the next counter wrap. If clkdiv is lowered below the current count, the counter wraps on the next cycle (the ≥ compare).
- rst mid-frame: the frame is aborted, tx_line=1 on the next cycle, and queued data is discarded.

Test Plan:
- Reset, clkdiv=4, write 0xA5, parity 0, one stop -> tx_line holds each bit for 4 clocks in order 0,1,0,1,0,0,1,0,1,1; busy for 40 clocks; FIFO level returns to 2^SIZE.
- parity_mode=1 with 0x07, then parity_mode=2 with 0x07 -> parity bit 1 (even), then 0 (odd); two_stop=1 gives 2 stop bits.
- Write 3 chars back-to-back, clkdiv=1 -> 30 contiguous bit periods with no idle bit between frames; busy never drops.
- Fill FIFO (2^SIZE writes) plus one extra -> fifo_full=1, extra char never transmitted, fifo_level=0.
- phase_inc=2^(PHASE_W-LUT_ADDR_W), SAMPLE_WIDTH=8 -> during the start bit ask_tx steps through LUT entries 0,1,2… one per clock with peak 127; ask_tx=0 during 1-bits.
- Assert rst mid-DATA -> tx_line=1 and ask_tx=0 next cycle; busy=0; a following write transmits cleanly.

Source files
------------

// File: rtl/ask_uart_tx_multi_if.sv
// CPU/DAC-side bundle of the ASK UART transmitter: character queue, line
// configuration, raw UART line and keyed carrier samples.
interface ask_uart_tx_multi_if #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned PHASE_W      = 16
);
  logic [DATA_BITS-1:0]           fifo_in;
  logic                           fifo_write;
  logic                           fifo_full;
  logic [15:0]                    fifo_level;
  logic [15:0]                    clkdiv;
  logic [PHASE_W-1:0]             phase_inc;
  logic [1:0]                     parity_mode;
  logic                           two_stop;
  logic                           tx_line;
  logic signed [SAMPLE_WIDTH-1:0] ask_tx;
  logic                           baudclk;
  logic                           busy;

  modport master (
    output fifo_in, fifo_write, clkdiv, phase_inc, parity_mode, two_stop,
    input  fifo_full, fifo_level, tx_line, ask_tx, baudclk, busy
  );

  modport slave (
    input  fifo_in, fifo_write, clkdiv, phase_inc, parity_mode, two_stop,
    output fifo_full, fifo_level, tx_line, ask_tx, baudclk, busy
  );
endinterface

// File: rtl/ask_uart_tx_multi.sv
// Buffered UART framer whose line bits key a LUT-based sine carrier,
// producing a signed ASK sample stream for a DAC.
module ask_uart_tx_multi #(
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned SAMPLE_WIDTH     = 8,
  parameter int unsigned SIZE             = 4,
  parameter int unsigned LUT_ADDR_W       = 6,
  parameter int unsigned PHASE_W          = 16,
  parameter int unsigned CARRIER_ON_SPACE = 1
) (
  input logic                clk,
  input logic                rst,
  ask_uart_tx_multi_if.slave bus
);
  localparam int unsigned DEPTH     = 1 << SIZE;
  localparam int unsigned LUT_N     = 1 << LUT_ADDR_W;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
  localparam longint      PI_FX     = 64'sd3373259426; // pi * 2^30
  localparam int unsigned FX_SH     = 30;

  // Integer-only floor(amp*sin(2*pi*k/LUT_N)); quadrant folding keeps the
  // exact points (0, +/-amp) exact and the Taylor series only sees [0, pi/2).
  function automatic logic signed [SAMPLE_WIDTH-1:0] sine_entry(input int unsigned k);
    int unsigned r, j;
    bit          neg;
    longint      amp, x, x2, term, sum, mag, val;
    neg = (k >= LUT_N / 2);
    r   = neg ? (k - LUT_N / 2) : k;
    j   = (r > LUT_N / 4) ? (LUT_N / 2 - r) : r;
    amp = (longint'(1) <<< (SAMPLE_WIDTH - 1)) - 1;
    if (j == 0) begin
      mag = 0;
    end else if (j == LUT_N / 4) begin
      mag = amp <<< FX_SH;
    end else begin
      x    = (2 * PI_FX * longint'(j)) / longint'(LUT_N);
      x2   = (x * x) >>> FX_SH;
      term = x;
      sum  = x;
      for (int n = 1; n <= 9; n++) begin
        term = -((term * x2) >>> FX_SH) / longint'((2 * n) * (2 * n + 1));
        sum  = sum + term;
      end
      mag = amp * sum;
    end
    val = neg ? -((mag + (longint'(1) <<< FX_SH) - 1) >>> FX_SH) : (mag >>> FX_SH);
    return SAMPLE_WIDTH'(val);
  endfunction

  logic signed [SAMPLE_WIDTH-1:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic signed [SAMPLE_WIDTH-1:0] ENTRY = sine_entry(k);
    assign lut[k] = ENTRY;
  end

  // Character FIFO
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [SIZE-1:0]      wr_ptr, rd_ptr;
  logic [SIZE:0]        count, count_nxt;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_empty, push, pop;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign push       = bus.fifo_write && !bus.fifo_full;
  assign count_nxt  = count + (SIZE + 1)'(push) - (SIZE + 1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.fifo_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.fifo_full  <= 1'b0;
      bus.fifo_level <= 16'(DEPTH);
    end else begin
      if (push) wr_ptr <= wr_ptr + SIZE'(1);
      if (pop)  rd_ptr <= rd_ptr + SIZE'(1);
      count          <= count_nxt;
      bus.fifo_full  <= (count_nxt == (SIZE + 1)'(DEPTH));
      bus.fifo_level <= 16'(DEPTH) - 16'(count_nxt);
    end
  end

  // Baud counter; the >= compare lets a lowered clkdiv wrap immediately
  logic [15:0] baud_cnt, div;
  logic        bit_tick;

  assign div      = (bus.clkdiv == 16'd0) ? 16'd1 : bus.clkdiv;
  assign bit_tick = (baud_cnt >= div);

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt    <= 16'd0;
      bus.baudclk <= 1'b0;
    end else begin
      baud_cnt    <= bit_tick ? 16'd1 : baud_cnt + 16'd1;
      bus.baudclk <= bit_tick;
    end
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                         state_q, state_nxt;
  logic [DATA_BITS-1:0]           shift_q, shift_nxt;
  logic [BIT_IDX_W-1:0]           bit_idx_q, bit_idx_nxt;
  logic                           stop_idx_q, stop_idx_nxt;
  logic                           par_en_q, par_en_nxt;
  logic                           par_bit_q, par_bit_nxt;
  logic                           two_stop_q, two_stop_nxt;
  logic [PHASE_W-1:0]             phase_q, phase_nxt;
  logic                           line_nxt, busy_nxt, key_on;
  logic signed [SAMPLE_WIDTH-1:0] ask_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      two_stop_q  <= 1'b0;
      phase_q     <= '0;
      bus.tx_line <= 1'b1;
      bus.busy    <= 1'b0;
      bus.ask_tx  <= '0;
    end else begin
      state_q     <= state_nxt;
      shift_q     <= shift_nxt;
      bit_idx_q   <= bit_idx_nxt;
      stop_idx_q  <= stop_idx_nxt;
      par_en_q    <= par_en_nxt;
      par_bit_q   <= par_bit_nxt;
      two_stop_q  <= two_stop_nxt;
      phase_q     <= phase_nxt;
      bus.tx_line <= line_nxt;
      bus.busy    <= busy_nxt;
      bus.ask_tx  <= ask_nxt;
    end
  end

  // Framing FSM; every transition waits for a bit boundary
  always_comb begin
    state_nxt    = state_q;
    shift_nxt    = shift_q;
    bit_idx_nxt  = bit_idx_q;
    stop_idx_nxt = stop_idx_q;
    par_en_nxt   = par_en_q;
    par_bit_nxt  = par_bit_q;
    two_stop_nxt = two_stop_q;
    pop          = 1'b0;
    line_nxt     = 1'b1;

    if (bit_tick) begin
      case (state_q)
        IDLE:   pop = !fifo_empty;
        START: begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
        DATA: begin
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_nxt    = par_en_q ? PARITY : STOP;
            stop_idx_nxt = 1'b0;
          end else begin
            shift_nxt   = shift_q >> 1;
            bit_idx_nxt = bit_idx_q + BIT_IDX_W'(1);
          end
        end
        PARITY: begin
          state_nxt    = STOP;
          stop_idx_nxt = 1'b0;
        end
        STOP: begin
          if (two_stop_q && !stop_idx_q) stop_idx_nxt = 1'b1;
          else if (!fifo_empty)          pop = 1'b1;
          else                           state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Frame load: latch head and its config, pop in the same cycle
    if (pop) begin
      state_nxt    = START;
      shift_nxt    = head;
      par_en_nxt   = (bus.parity_mode == 2'd1) || (bus.parity_mode == 2'd2);
      par_bit_nxt  = (^head) ^ (bus.parity_mode == 2'd2);
      two_stop_nxt = bus.two_stop;
    end

    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift_nxt[0];
      PARITY:  line_nxt = par_bit_nxt;
      default: line_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Carrier phase and keyed sample, one cycle behind tx_line
  always_comb begin
    phase_nxt = pop ? '0 : phase_q + bus.phase_inc;
    key_on    = (CARRIER_ON_SPACE != 0) ? !bus.tx_line : bus.tx_line;
    ask_nxt   = key_on ? lut[phase_q[PHASE_W-1 -: LUT_ADDR_W]] : '0;
  end
endmodule

// File: tb/tb_ask_uart_tx_multi.sv
// Self-checking bench for ask_uart_tx_multi: a line monitor decodes frames
// against a scoreboard of queued characters, plus directed corner sequences.
module tb_ask_uart_tx_multi;
  localparam int unsigned DB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ask_uart_tx_multi_if bus_if ();
  ask_uart_tx_multi dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par;
    int         nstop;
    int         div;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pmode;
    bit          two;
    logic [15:0] clkdiv;
    bit          exp_par_en;
    bit          exp_par;
    int          exp_nstop;
    int          exp_div;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   lut_ref[20];
  int   errors = 0;
  int   checks = 0;
  int   frames_done = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_char(input logic [7:0] d);
    bus_if.fifo_in    = d;
    bus_if.fifo_write = 1'b1;
    @(negedge clk);
    bus_if.fifo_write = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input bit pe, input bit p,
                          input int ns, input int dv);
    exp_t e;
    e.data = d; e.par_en = pe; e.par = p; e.nstop = ns; e.div = dv;
    sb.push_back(e);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("frames_done", frames_done, target);
    @(negedge clk);
  endtask

  // Decode one frame starting at the current (start-bit) cycle
  task automatic decode_frame();
    exp_t e;
    int   nbits, w;
    logic v, got_line, got_busy;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: start bit seen, expected no frame");
      w = 0;
      while (bus_if.busy && w < 5000) begin
        @(negedge clk);
        w++;
      end
      return;
    end
    e = sb.pop_front();
    nbits = 1 + DB + (e.par_en ? 1 : 0) + e.nstop;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                          v = 1'b0;
      else if (b <= DB)                    v = e.data[b-1];
      else if (e.par_en && b == DB + 1)    v = e.par;
      else                                 v = 1'b1;
      got_line = v;
      got_busy = 1'b1;
      for (int c = 0; c < e.div; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (bus_if.tx_line !== v)   got_line = bus_if.tx_line;
        if (bus_if.busy !== 1'b1)   got_busy = bus_if.busy;
      end
      check($sformatf("frame%0d_data%02h_bit%0d_line", frames_done, e.data, b), got_line, v);
      check($sformatf("frame%0d_bit%0d_busy", frames_done, b), got_busy, 1);
    end
    frames_done++;
  endtask

  always begin
    @(negedge clk);
    if (mon_en && !rst && bus_if.tx_line === 1'b0) decode_frame();
  end

  initial begin
    int w, run, base;

    vecs[0] = '{8'hA5, 2'd0, 1'b0, 16'd4, 1'b0, 1'b0, 1, 4};
    vecs[1] = '{8'h07, 2'd1, 1'b0, 16'd3, 1'b1, 1'b1, 1, 3};
    vecs[2] = '{8'h07, 2'd2, 1'b0, 16'd3, 1'b1, 1'b0, 1, 3};
    vecs[3] = '{8'h07, 2'd1, 1'b1, 16'd2, 1'b1, 1'b1, 2, 2};
    vecs[4] = '{8'h00, 2'd2, 1'b1, 16'd5, 1'b1, 1'b1, 2, 5};
    vecs[5] = '{8'hFF, 2'd1, 1'b0, 16'd1, 1'b1, 1'b0, 1, 1};
    vecs[6] = '{8'h80, 2'd3, 1'b1, 16'd2, 1'b0, 1'b0, 2, 2};
    vecs[7] = '{8'h3C, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1, 1};
    for (int k = 0; k < 20; k++)
      lut_ref[k] = int'($floor(127.0 * $sin(2.0 * 3.141592653589793 * k / 64.0)));

    rst                = 1'b1;
    bus_if.fifo_in     = '0;
    bus_if.fifo_write  = 1'b0;
    bus_if.clkdiv      = 16'd4;
    bus_if.phase_inc   = '0;
    bus_if.parity_mode = 2'd0;
    bus_if.two_stop    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_line", bus_if.tx_line, 1);
    check("rst_ask_tx", bus_if.ask_tx, 0);
    check("rst_baudclk", bus_if.baudclk, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_fifo_full", bus_if.fifo_full, 0);
    check("rst_fifo_level", bus_if.fifo_level, 16);
    rst = 1'b0;

    // baudclk: single-cycle pulse every clkdiv clocks
    bus_if.clkdiv = 16'd3;
    w = 0;
    while (bus_if.baudclk !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("baudclk_first_pulse", bus_if.baudclk, 1);
    @(negedge clk); check("baudclk_gap1", bus_if.baudclk, 0);
    @(negedge clk); check("baudclk_gap2", bus_if.baudclk, 0);
    @(negedge clk); check("baudclk_period", bus_if.baudclk, 1);

    mon_en = 1'b1;
    base   = 0;
    for (int i = 0; i < 8; i++) begin
      bus_if.clkdiv      = vecs[i].clkdiv;
      bus_if.parity_mode = vecs[i].pmode;
      bus_if.two_stop    = vecs[i].two;
      push_exp(vecs[i].data, vecs[i].exp_par_en, vecs[i].exp_par,
               vecs[i].exp_nstop, vecs[i].exp_div);
      write_char(vecs[i].data);
      base++;
      wait_frames(base, 2000);
      check($sformatf("vec%0d_busy_after", i), bus_if.busy, 0);
      check($sformatf("vec%0d_line_after", i), bus_if.tx_line, 1);
      check($sformatf("vec%0d_level_after", i), bus_if.fifo_level, 16);
    end

    // Three back-to-back frames at clkdiv=1: one continuous 30-clock busy run
    bus_if.clkdiv      = 16'd1;
    bus_if.parity_mode = 2'd0;
    bus_if.two_stop    = 1'b0;
    push_exp(8'h3C, 0, 0, 1, 1);
    push_exp(8'hC3, 0, 0, 1, 1);
    push_exp(8'h81, 0, 0, 1, 1);
    run = 0;
    fork
      begin
        write_char(8'h3C);
        write_char(8'hC3);
        write_char(8'h81);
      end
      begin
        w = 0;
        while (bus_if.busy !== 1'b1 && w < 50) begin
          @(negedge clk);
          w++;
        end
        while (bus_if.busy === 1'b1 && run < 200) begin
          run++;
          @(negedge clk);
        end
      end
    join
    check("b2b_busy_run", run, 30);
    base += 3;
    wait_frames(base, 500);

    // Fill FIFO with the baud tick parked, one extra write must be dropped
    bus_if.clkdiv = 16'hFFFF;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_exp(8'(i * 13 + 7), 0, 0, 1, 2);
      write_char(8'(i * 13 + 7));
      if (i == 7) check("fill_level_half", bus_if.fifo_level, 8);
    end
    check("fill_full_at_16", bus_if.fifo_full, 1);
    write_char(8'hEE);
    check("fill_full_after_extra", bus_if.fifo_full, 1);
    check("fill_level_zero", bus_if.fifo_level, 0);
    bus_if.clkdiv = 16'd2;
    base += 16;
    wait_frames(base, 1000);
    repeat (60) @(negedge clk);
    check("fill_scoreboard_empty", sb.size(), 0);
    check("fill_frames_total", frames_done, base);
    check("fill_level_restored", bus_if.fifo_level, 16);
    check("fill_not_full", bus_if.fifo_full, 0);

    // Keyed carrier: start bit walks the LUT, 1-bits are silent
    bus_if.clkdiv    = 16'd20;
    bus_if.phase_inc = 16'd1024;
    push_exp(8'hFF, 0, 0, 1, 20);
    fork
      write_char(8'hFF);
      begin
        w = 0;
        while (bus_if.tx_line !== 1'b0 && w < 100) begin
          @(negedge clk);
          w++;
        end
        check("ask_start_seen", bus_if.tx_line, 0);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          check($sformatf("ask_lut%0d", i), bus_if.ask_tx, lut_ref[i]);
        end
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          check($sformatf("ask_mark%0d", i), bus_if.ask_tx, 0);
        end
      end
    join
    base++;
    wait_frames(base, 1000);

    // Reset mid-DATA: immediate idle line, silence, queue discarded
    mon_en        = 1'b0;
    bus_if.clkdiv = 16'd4;
    write_char(8'h00);
    write_char(8'h11);
    w = 0;
    while (bus_if.tx_line !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (12) @(negedge clk);
    check("pre_rst_busy", bus_if.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx_line", bus_if.tx_line, 1);
    check("midrst_ask_tx", bus_if.ask_tx, 0);
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_level", bus_if.fifo_level, 16);
    @(negedge clk);
    rst                = 1'b0;
    mon_en             = 1'b1;
    bus_if.parity_mode = 2'd1;
    push_exp(8'h5A, 1, 0, 1, 4);
    write_char(8'h5A);
    base++;
    wait_frames(base, 1000);
    repeat (80) @(negedge clk);
    check("post_rst_scoreboard_empty", sb.size(), 0);
    check("post_rst_frames_total", frames_done, base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
